// File: rtl/hv_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hv_bist_ctrl_if
// Brief    : Control/status bundle between the HV BIST sequencer, the control
//            FSM, the analog test block and the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface hv_bist_ctrl_if #(
    parameter int BIST_ITEM_NUM = 4
);
    logic                     i_bist_en;
    logic [BIST_ITEM_NUM-1:0] i_bist_item_mask;
    logic [BIST_ITEM_NUM-1:0] i_ang_bist_rsp;
    logic [BIST_ITEM_NUM-1:0] o_ang_bist_sel;
    logic                     o_bist_busy;
    logic                     o_bist_done;
    logic                     o_bist_fail;
    logic [BIST_ITEM_NUM-1:0] o_bist_fail_vec;

    modport slave (
        input  i_bist_en, i_bist_item_mask, i_ang_bist_rsp,
        output o_ang_bist_sel, o_bist_busy, o_bist_done, o_bist_fail, o_bist_fail_vec
    );

    modport master (
        output i_bist_en, i_bist_item_mask, i_ang_bist_rsp,
        input  o_ang_bist_sel, o_bist_busy, o_bist_done, o_bist_fail, o_bist_fail_vec
    );
endinterface
`default_nettype wire

// File: rtl/hv_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hv_bist_ctrl
// Brief    : Analog BIST sequencer: select, settle, check each enabled item.
//            Optional macro HV_BIST_RETRY_EN gives each failing item one retry.
// Revision : 1.0 - initial release
// ============================================================================
module hv_bist_ctrl #(
    parameter int BIST_ITEM_NUM = 4,
    parameter int SETTLE_CYC    = 16,
    parameter int CHECK_CYC     = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    hv_bist_ctrl_if.slave        bist_if
);
    localparam int IW = $clog2(BIST_ITEM_NUM + 1);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int CW = $clog2(CHECK_CYC + 1);

    localparam logic [IW-1:0] C_IDX_END  = IW'(BIST_ITEM_NUM);
    localparam logic [SW-1:0] C_SET_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] C_CHK_LAST = CW'(CHECK_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SCAN = 3'd1,
        ST_SEL  = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                   state_q;
    logic                     start_q;
    logic [IW-1:0]            idx_q;
    logic [SW-1:0]            set_cnt_q;
    logic [CW-1:0]            chk_cnt_q;
    logic [BIST_ITEM_NUM-1:0] sel_q;
    logic                     busy_q;
    logic                     done_q;
    logic                     fail_q;
    logic [BIST_ITEM_NUM-1:0] fail_vec_q;
`ifdef HV_BIST_RETRY_EN
    logic                     retry_q;
`endif

    logic [BIST_ITEM_NUM-1:0] w_idx_oh;
    logic                     w_mask_hit;
    logic                     w_rsp_ok;

    // idx == BIST_ITEM_NUM shifts the one-hot out entirely, so no mask bit hits.
    assign w_idx_oh   = BIST_ITEM_NUM'(1) << idx_q;
    assign w_mask_hit = |(bist_if.i_bist_item_mask & w_idx_oh);
    assign w_rsp_ok   = |(bist_if.i_ang_bist_rsp & sel_q);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            idx_q      <= '0;
            set_cnt_q  <= '0;
            chk_cnt_q  <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            fail_vec_q <= '0;
`ifdef HV_BIST_RETRY_EN
            retry_q    <= 1'b0;
`endif
        end else begin
            fail_q <= |fail_vec_q;
            if (state_q != ST_IDLE && !bist_if.i_bist_en) begin
                // Abort: the fail vector survives so software can still read it.
                state_q <= ST_IDLE;
                idx_q   <= '0;
                sel_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
`ifdef HV_BIST_RETRY_EN
                retry_q <= 1'b0;
`endif
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Start takes two edges: clear results, then enter SCAN.
                        if (!bist_if.i_bist_en) begin
                            start_q <= 1'b0;
                        end else if (!start_q) begin
                            start_q    <= 1'b1;
                            idx_q      <= '0;
                            fail_vec_q <= '0;
                        end else begin
                            start_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (idx_q == C_IDX_END) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (w_mask_hit) begin
                            state_q   <= ST_SEL;
                            sel_q     <= w_idx_oh;
                            set_cnt_q <= '0;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                    ST_SEL: begin
                        if (set_cnt_q == C_SET_LAST) begin
                            state_q   <= ST_CHK;
                            chk_cnt_q <= '0;
                        end else begin
                            set_cnt_q <= set_cnt_q + SW'(1);
                        end
                    end
                    ST_CHK: begin
                        if (!w_rsp_ok) begin
`ifdef HV_BIST_RETRY_EN
                            if (!retry_q) begin
                                retry_q   <= 1'b1;
                                state_q   <= ST_SEL;
                                set_cnt_q <= '0;
                            end else begin
                                retry_q    <= 1'b0;
                                fail_vec_q <= fail_vec_q | sel_q;
                                sel_q      <= '0;
                                idx_q      <= idx_q + IW'(1);
                                state_q    <= ST_SCAN;
                            end
`else
                            fail_vec_q <= fail_vec_q | sel_q;
                            sel_q      <= '0;
                            idx_q      <= idx_q + IW'(1);
                            state_q    <= ST_SCAN;
`endif
                        end else if (chk_cnt_q == C_CHK_LAST) begin
`ifdef HV_BIST_RETRY_EN
                            retry_q <= 1'b0;
`endif
                            sel_q   <= '0;
                            idx_q   <= idx_q + IW'(1);
                            state_q <= ST_SCAN;
                        end else begin
                            chk_cnt_q <= chk_cnt_q + CW'(1);
                        end
                    end
                    ST_DONE: begin
                        done_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        sel_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bist_if.o_ang_bist_sel  = sel_q;
    assign bist_if.o_bist_busy     = busy_q;
    assign bist_if.o_bist_done     = done_q;
    assign bist_if.o_bist_fail     = fail_q;
    assign bist_if.o_bist_fail_vec = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_hv_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hv_bist_ctrl
// Brief    : Directed self-checking bench for hv_bist_ctrl at default params.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hv_bist_ctrl;
    localparam int N = 4;
    localparam int S = 16;
    localparam int C = 4;

`ifdef HV_BIST_RETRY_EN
    localparam int EXP_FAIL_DONE  = 104;
    localparam int EXP_FAIL_VEC   = 0;
    localparam int EXP_FAIL_FLAG  = 0;
    localparam int EXP_ITEM2_SEL  = 38;
    localparam int EXP_FV_EDGE    = -1;
    localparam int EXP_FLAG_EDGE  = -1;
    localparam int ABORT_M        = 45;
`else
    localparam int EXP_FAIL_DONE  = 84;
    localparam int EXP_FAIL_VEC   = 4;
    localparam int EXP_FAIL_FLAG  = 1;
    localparam int EXP_ITEM2_SEL  = 18;
    localparam int EXP_FV_EDGE    = 62;
    localparam int EXP_FLAG_EDGE  = 63;
    localparam int ABORT_M        = 30;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hv_bist_ctrl_if #(.BIST_ITEM_NUM(N)) bist_if ();

    hv_bist_ctrl #(
        .BIST_ITEM_NUM (N),
        .SETTLE_CYC    (S),
        .CHECK_CYC     (C)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bist_if (bist_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    int r_busy_edge, r_done_edge, r_fv_edge, r_flag_edge, r_bad_sel, r_busy_at_done;
    int r_sel_cyc [N];

    // Called at a negedge with en low; observation m is the state after edge E0+m.
    task automatic run_seq(input logic [N-1:0] mask, input int fail_edge, input int budget);
        r_busy_edge = -1; r_done_edge = -1; r_fv_edge = -1; r_flag_edge = -1;
        r_bad_sel = 0; r_busy_at_done = -1;
        for (int k = 0; k < N; k++) r_sel_cyc[k] = 0;
        bist_if.i_bist_item_mask = mask;
        bist_if.i_ang_bist_rsp   = '1;
        bist_if.i_bist_en        = 1'b1;
        for (int m = 0; m <= budget; m++) begin
            @(negedge clk);
            if (bist_if.o_bist_busy && r_busy_edge < 0) r_busy_edge = m;
            if (bist_if.o_bist_fail_vec != '0 && r_fv_edge < 0) r_fv_edge = m;
            if (bist_if.o_bist_fail && r_flag_edge < 0) r_flag_edge = m;
            if (bist_if.o_ang_bist_sel != '0) begin
                if (!$onehot(bist_if.o_ang_bist_sel)) r_bad_sel++;
                for (int k = 0; k < N; k++)
                    if (bist_if.o_ang_bist_sel[k]) r_sel_cyc[k]++;
            end
            if (bist_if.o_bist_done) begin
                r_done_edge    = m;
                r_busy_at_done = int'(bist_if.o_bist_busy);
                break;
            end
            if (fail_edge >= 0) bist_if.i_ang_bist_rsp[2] = (m == fail_edge - 1) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic go_idle();
        bist_if.i_bist_en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bist_if.i_bist_en        = 1'b0;
        bist_if.i_bist_item_mask = '0;
        bist_if.i_ang_bist_rsp   = '1;
        repeat (3) @(negedge clk);
        chk("rst_sel",  32'(bist_if.o_ang_bist_sel), 0);
        chk("rst_busy", 32'(bist_if.o_bist_busy), 0);
        chk("rst_done", 32'(bist_if.o_bist_done), 0);
        chk("rst_flag", 32'(bist_if.o_bist_fail), 0);
        chk("rst_fv",   32'(bist_if.o_bist_fail_vec), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All items enabled and passing
        run_seq(4'hF, -1, 150);
        chk("all_busy_edge", r_busy_edge, 1);
        chk("all_done_edge", r_done_edge, 86);
        chk("all_busy_at_done", r_busy_at_done, 0);
        for (int k = 0; k < N; k++) chk($sformatf("all_sel_cyc%0d", k), r_sel_cyc[k], 20);
        chk("all_onehot", r_bad_sel, 0);
        chk("all_flag", 32'(bist_if.o_bist_fail), 0);
        chk("all_fv", 32'(bist_if.o_bist_fail_vec), 0);
        @(negedge clk);
        chk("all_done_hold", 32'(bist_if.o_bist_done), 1);
        bist_if.i_bist_en = 1'b0;
        @(negedge clk);
        chk("all_done_drop", 32'(bist_if.o_bist_done), 0);
        go_idle();

        // Everything masked
        run_seq(4'h0, -1, 150);
        chk("mask0_done_edge", r_done_edge, 6);
        chk("mask0_sel_total", r_sel_cyc[0] + r_sel_cyc[1] + r_sel_cyc[2] + r_sel_cyc[3], 0);
        chk("mask0_flag", 32'(bist_if.o_bist_fail), 0);
        go_idle();

        // Item 2 response low on its 2nd check cycle (edge E0+62)
        run_seq(4'hF, 62, 150);
        chk("f2_done_edge", r_done_edge, EXP_FAIL_DONE);
        chk("f2_fv", 32'(bist_if.o_bist_fail_vec), EXP_FAIL_VEC);
        chk("f2_flag", 32'(bist_if.o_bist_fail), EXP_FAIL_FLAG);
        chk("f2_sel2_cyc", r_sel_cyc[2], EXP_ITEM2_SEL);
        chk("f2_fv_edge", r_fv_edge, EXP_FV_EDGE);
        chk("f2_flag_edge", r_flag_edge, EXP_FLAG_EDGE);
        chk("f2_onehot", r_bad_sel, 0);
        go_idle();

        // Item 0 always fails; abort during SEL of item 1
        bist_if.i_bist_item_mask = 4'hF;
        bist_if.i_ang_bist_rsp   = 4'hE;
        bist_if.i_bist_en        = 1'b1;
        for (int m = 0; m <= ABORT_M; m++) @(negedge clk);
        chk("ab_pre_sel", 32'(bist_if.o_ang_bist_sel), 2);
        chk("ab_pre_fv", 32'(bist_if.o_bist_fail_vec), 1);
        bist_if.i_bist_en = 1'b0;
        @(negedge clk);
        chk("ab_sel", 32'(bist_if.o_ang_bist_sel), 0);
        chk("ab_busy", 32'(bist_if.o_bist_busy), 0);
        chk("ab_done", 32'(bist_if.o_bist_done), 0);
        bist_if.i_ang_bist_rsp = 4'hF;
        repeat (2) @(negedge clk);
        chk("ab_fv_kept", 32'(bist_if.o_bist_fail_vec), 1);
        chk("ab_flag_kept", 32'(bist_if.o_bist_fail), 1);
        bist_if.i_bist_en = 1'b1;
        @(negedge clk);
        chk("rs_fv_clr", 32'(bist_if.o_bist_fail_vec), 0);
        @(negedge clk);
        chk("rs_busy", 32'(bist_if.o_bist_busy), 1);
        chk("rs_flag_clr", 32'(bist_if.o_bist_fail), 0);
        @(negedge clk);
        chk("rs_sel0", 32'(bist_if.o_ang_bist_sel), 1);
        go_idle();

        // Asynchronous reset during CHK of item 0
        bist_if.i_bist_en = 1'b1;
        for (int m = 0; m <= 19; m++) @(negedge clk);
        chk("ar_pre_sel", 32'(bist_if.o_ang_bist_sel), 1);
        rst_n = 1'b0;
        #1;
        chk("ar_sel", 32'(bist_if.o_ang_bist_sel), 0);
        chk("ar_busy", 32'(bist_if.o_bist_busy), 0);
        bist_if.i_bist_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("ar_idle_busy", 32'(bist_if.o_bist_busy), 0);
        bist_if.i_bist_en = 1'b1;
        @(negedge clk);
        chk("ar_e0_busy", 32'(bist_if.o_bist_busy), 0);
        @(negedge clk);
        chk("ar_e1_busy", 32'(bist_if.o_bist_busy), 1);
        go_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
